// File: rtl/noc_dma_rd.sv
// noc_dma_rd: AXI4 read-DMA engine; fetches num_beats beats as INCR bursts into a local operand buffer.
// Optional feature macro NOC_DMA_RD_4K_GUARD_EN: clip bursts so none crosses a 4 KB address boundary.
module noc_dma_rd #(
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 128,
  parameter int BUF_AW    = 10,
  parameter int MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [BUF_AW:0]   num_beats,
  output logic              done,
  output logic              error,
  output logic              busy,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [7:0]        m_arlen,
  output logic [2:0]        m_arsize,
  output logic [1:0]        m_arburst,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rlast,
  input  logic              m_rvalid,
  output logic              m_rready,
  output logic              buf_we,
  output logic [BUF_AW-1:0] buf_addr,
  output logic [DATA_W-1:0] buf_wdata
);

  localparam int BYTES_LG = $clog2(DATA_W / 8);
  localparam int CW       = (BUF_AW + 1 > 13) ? BUF_AW + 1 : 13;

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_DONE, S_ERR} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_addr;
  logic [BUF_AW:0]   r_remaining;
  logic [8:0]        r_burst_left;
  logic              r_err;
  logic [BUF_AW-1:0] r_beat_idx;
  logic [BUF_AW-1:0] r_buf_addr;
  logic              r_buf_we;
  logic [DATA_W-1:0] r_buf_wdata;

  logic [CW-1:0]     w_rem;
  logic [CW-1:0]     w_burst;
  logic              w_exp_last;
  logic              w_beat_err;

`ifdef NOC_DMA_RD_4K_GUARD_EN
  logic [12:0]       w_to_4k_bytes;
  logic [CW-1:0]     w_to_4k;
  assign w_to_4k_bytes = 13'h1000 - {1'b0, r_addr[11:0]};
  assign w_to_4k       = CW'(w_to_4k_bytes >> BYTES_LG);
`endif

  // Burst size depends only on registers, so AR fields stay stable while waiting for arready.
  always_comb begin
    w_rem   = CW'(r_remaining);
    w_burst = (w_rem < CW'(MAX_BURST)) ? w_rem : CW'(MAX_BURST);
`ifdef NOC_DMA_RD_4K_GUARD_EN
    if (w_to_4k < w_burst) w_burst = w_to_4k;
`endif
  end

  assign w_exp_last = (r_burst_left == 9'd1);
  assign w_beat_err = (m_rresp != 2'b00) || (m_rlast != w_exp_last);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_state_next = (num_beats != '0) ? S_ADDR : S_DONE;
      S_ADDR: if (m_arready) w_state_next = S_DATA;
      // A burst ends only on rlast, so an erroneous burst is always drained completely.
      S_DATA: if (m_rvalid && m_rlast) begin
        if (r_err || w_beat_err)     w_state_next = S_ERR;
        else if (r_remaining != '0)  w_state_next = S_ADDR;
        else                         w_state_next = S_DONE;
      end
      S_DONE:  w_state_next = S_IDLE;
      S_ERR:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    done      = (r_state == S_DONE);
    error     = (r_state == S_ERR);
    busy      = (r_state != S_IDLE);
    m_arvalid = (r_state == S_ADDR);
    m_rready  = (r_state == S_DATA);
    m_araddr  = r_addr;
    m_arlen   = (r_state == S_ADDR) ? 8'(w_burst - CW'(1)) : 8'd0;
    m_arsize  = 3'(BYTES_LG);
    m_arburst = 2'b01;
    buf_we    = r_buf_we;
    buf_addr  = r_buf_addr;
    buf_wdata = r_buf_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr       <= '0;
      r_remaining  <= '0;
      r_burst_left <= '0;
      r_err        <= 1'b0;
      r_beat_idx   <= '0;
      r_buf_addr   <= '0;
      r_buf_we     <= 1'b0;
      r_buf_wdata  <= '0;
    end else begin
      r_buf_we <= 1'b0;
      case (r_state)
        S_IDLE: if (start) begin
          r_addr       <= base_addr;
          r_remaining  <= num_beats;
          r_burst_left <= '0;
          r_err        <= 1'b0;
          r_beat_idx   <= '0;
          r_buf_addr   <= '0;
        end
        S_ADDR: if (m_arready) begin
          r_addr       <= r_addr + (ADDR_W'(w_burst) << BYTES_LG);
          r_remaining  <= r_remaining - w_burst[BUF_AW:0];
          r_burst_left <= w_burst[8:0];
        end
        S_DATA: if (m_rvalid) begin
          if (r_burst_left != '0) r_burst_left <= r_burst_left - 9'd1;
          if (w_beat_err) r_err <= 1'b1;
          if (!w_beat_err && !r_err) begin
            r_buf_we    <= 1'b1;
            r_buf_addr  <= r_beat_idx;
            r_buf_wdata <= m_rdata;
            r_beat_idx  <= r_beat_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
